controlador_microondas: RTL and testbench
=========================================

Name: controlador_microondas

Overview:
Cook-cycle sequencer for the microwave.
- Loads a cook time, counts it down in seconds, and drives the magnetron enable `ligar`.
- Pauses on door-open or stop, resumes on start, clears on `clrn`.
- Raises a timed end-of-cook alarm.
- Sits between the front-panel inputs and the magnetron; replaces purely combinational gating of `ligar` with a clocked FSM.

Parameters:
TICKS_POR_SEG, 100, clk cycles per second tick (small value for simulation; set to clk Hz in silicon)
T_W, 12, width of time register in seconds (max 4095 s)
BEEP_SEG, 3, alarm duration in seconds

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
startn  in  1  start, active-low; acts on 1->0 transition
stopn  in  1  stop/pause, active-low; acts on 1->0 transition
clrn  in  1  clear, active-low, level-sensitive
porta_fechada  in  1  1 = door closed
carregar  in  1  load tempo_in into time register
tempo_in  in  T_W  cook time in seconds
ligar  out  1  magnetron enable
tempo_restante  out  T_W  remaining seconds
zero  out  1  tempo_restante == 0 (combinational from register)
alarme  out  1  end-of-cook alarm
estado  out  2  current FSM state

Behaviour:
- One clock. `rst` is asynchronous and active-high. All inputs are synchronous to `clk`.
- Edge detect: prev_start and prev_stop registers, reset to 1. An event occurs when the sampled value is 0 and the previous sample was 1.
- Reset values:
  - state = OCIOSO; tempo_restante = 0; prescaler = 0.
  - ligar = 0; alarme = 0; zero = 1.
- Priority, highest first: clrn low > door open > stop event > start event > carregar.
- Prescaler counts 0..TICKS_POR_SEG-1; tick = wrap.
- ligar and alarme are Moore decodes of the state register, so they change one clk after the causing input.

OCIOSO:
- carregar=1 -> tempo_restante <= tempo_in.
- Start event & porta_fechada & tempo_restante != 0 -> AQUECENDO, prescaler <= 0.
- Start with time 0 or door open is ignored.

AQUECENDO:
- ligar = 1.
- Each tick decrements tempo_restante. The tick that reaches 0 -> CONCLUIDO, prescaler <= 0.
- Door open -> PAUSADO. Tick suppressed that cycle; prescaler held.
- Stop event -> PAUSADO.
- carregar ignored.

PAUSADO:
- ligar = 0; prescaler and time held.
- Start event & porta_fechada -> AQUECENDO, prescaler retained (resume mid-second).
- Stop event -> OCIOSO, tempo_restante <= 0 (second stop cancels).
- carregar ignored.

CONCLUIDO:
- alarme = 1 for BEEP_SEG ticks, then OCIOSO.
- Stop event -> OCIOSO immediately, alarme drops.
- Start and door are ignored.

Any state:
- clrn == 0 -> OCIOSO, tempo_restante <= 0, prescaler <= 0.
- carregar is ignored while clrn is low.

Simultaneous events:
- Door-open with final tick -> PAUSADO, tempo_restante stays 1.
- Start and stop events in the same cycle: stop wins.

Optional Feature:
NIVEL_POTENCIA_EN
- Defined:
  - Adds input `nivel` [3:0], power level 1..10.
  - Values > 10 saturate to 10; 0 means magnetron never on.
  - A 0..9 second-window counter runs during AQUECENDO and holds in PAUSADO.
  - ligar = AQUECENDO & (window < nivel). Time countdown is unchanged.
- Undefined: no `nivel` port; ligar = AQUECENDO.

Decomposition:
- Package `microondas_pkg` holds:
  - state encoding OCIOSO=0, AQUECENDO=1, PAUSADO=2, CONCLUIDO=3;
  - default T_W and TICKS_POR_SEG constants.
- One sub-module, `contador_tempo`:
  - prescaler plus loadable seconds down-counter;
  - inputs load/en/clr, outputs tick and zero.
- FSM and edge detection stay in the top module.

Test Plan:
All scenarios use TICKS_POR_SEG=4.
1. Load 3, start event -> ligar=1 next clk. After 12 clks: zero=1, state CONCLUIDO, ligar=0, alarme=1 for 12 clks, then OCIOSO.
2. Load 5, start; open door at tempo_restante=2 -> ligar=0 next clk, time stays 2. Close door + start -> resumes, reaches 0 with prescaler phase retained.
3. Cooking, stop event -> PAUSADO. Second stop event -> OCIOSO, tempo_restante=0.
   - stopn held low continuously produces only one event.
4. Start with tempo_restante=0 -> stays OCIOSO. Load 2, start with door open -> ignored. Close door + start -> AQUECENDO.
5. clrn=0 during AQUECENDO with carregar=1, tempo_in=9 -> OCIOSO, tempo_restante=0, ligar=0. rst pulse mid-cook -> all outputs at reset values immediately.
6. tempo_restante=1, door opens on the final-tick cycle -> PAUSADO, tempo_restante=1, no alarme.
   - With NIVEL_POTENCIA_EN, nivel=3, load 10: ligar high 12 clks, low 28 clks.

Source files
------------

// File: rtl/microondas_pkg.sv
// Shared types and default constants for the microwave cook-cycle controller.
// Optional feature macro used by the design files: NIVEL_POTENCIA_EN.
package microondas_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    AQUECENDO = 2'd1,
    PAUSADO   = 2'd2,
    CONCLUIDO = 2'd3
  } estado_t;

  localparam int T_W_PADRAO           = 12;
  localparam int TICKS_POR_SEG_PADRAO = 100;
  localparam int BEEP_SEG_PADRAO      = 3;
  localparam int NIVEL_MAX            = 10;

  // Power levels above the maximum behave as the maximum.
  function automatic logic [3:0] satura_nivel(input logic [3:0] n);
    return (n > 4'(NIVEL_MAX)) ? 4'(NIVEL_MAX) : n;
  endfunction

endpackage

// File: rtl/controlador_microondas_if.sv
// Front-panel / magnetron signal bundle for controlador_microondas.
// The nivel input exists only when NIVEL_POTENCIA_EN is defined.
interface controlador_microondas_if #(
  parameter int T_W = microondas_pkg::T_W_PADRAO
);
  logic           startn;
  logic           stopn;
  logic           clrn;
  logic           porta_fechada;
  logic           carregar;
  logic [T_W-1:0] tempo_in;
`ifdef NIVEL_POTENCIA_EN
  logic [3:0]     nivel;
`endif
  logic           ligar;
  logic [T_W-1:0] tempo_restante;
  logic           zero;
  logic           alarme;
  logic [1:0]     estado;

  // Panel side drives the controls and observes the status.
  modport master (
    output startn, stopn, clrn, porta_fechada, carregar, tempo_in,
`ifdef NIVEL_POTENCIA_EN
    output nivel,
`endif
    input  ligar, tempo_restante, zero, alarme, estado
  );

  modport slave (
    input  startn, stopn, clrn, porta_fechada, carregar, tempo_in,
`ifdef NIVEL_POTENCIA_EN
    input  nivel,
`endif
    output ligar, tempo_restante, zero, alarme, estado
  );

endinterface

// File: rtl/contador_tempo.sv
// Second prescaler plus loadable seconds down-counter; tick marks the
// prescaler wrap while counting is enabled.
module contador_tempo #(
  parameter int TICKS_POR_SEG = microondas_pkg::TICKS_POR_SEG_PADRAO,
  parameter int T_W           = microondas_pkg::T_W_PADRAO
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           load,
  input  logic [T_W-1:0] load_val,
  input  logic           reinicia,
  input  logic           conta,
  input  logic           decr,
  output logic           tick,
  output logic           zero,
  output logic [T_W-1:0] tempo
);

  localparam int PW = (TICKS_POR_SEG > 1) ? $clog2(TICKS_POR_SEG) : 1;
  localparam logic [PW-1:0] ULTIMO = PW'(TICKS_POR_SEG - 1);

  logic [PW-1:0] pres;

  assign tick = conta && (pres == ULTIMO);
  assign zero = (tempo == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pres  <= '0;
      tempo <= '0;
    end else if (clr) begin
      pres  <= '0;
      tempo <= '0;
    end else begin
      // reinicia restarts the second phase; otherwise the phase is held when not counting
      if (reinicia)
        pres <= '0;
      else if (conta)
        pres <= tick ? '0 : pres + 1'b1;

      if (load)
        tempo <= load_val;
      else if (decr && tick && !zero)
        tempo <= tempo - 1'b1;
    end
  end

endmodule

// File: rtl/controlador_microondas.sv
// Cook-cycle sequencer: edge-detected start/stop, countdown, pause and alarm.
// Define NIVEL_POTENCIA_EN to add the nivel power-level duty cycle on ligar.
module controlador_microondas
  import microondas_pkg::*;
#(
  parameter int TICKS_POR_SEG = TICKS_POR_SEG_PADRAO,
  parameter int T_W           = T_W_PADRAO,
  parameter int BEEP_SEG      = BEEP_SEG_PADRAO
) (
  input logic clk,
  input logic rst,
  controlador_microondas_if.slave bus
);

  localparam int BW = (BEEP_SEG > 1) ? $clog2(BEEP_SEG + 1) : 1;
  localparam logic [BW-1:0] BEEP_ULT = BW'(BEEP_SEG - 1);

  estado_t estado, estado_prox;

  logic prev_start, prev_stop;
  logic ev_start, ev_stop;

  logic c_clr, c_load, c_reinicia, c_conta, c_decr;
  logic tick, zero;
  logic [T_W-1:0] tempo;

  logic          beep_clr;
  logic [BW-1:0] beep_cnt;

  // Panel buttons act once per press (1->0), however long they are held.
  assign ev_start = ~bus.startn & prev_start;
  assign ev_stop  = ~bus.stopn  & prev_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_start <= 1'b1;
      prev_stop  <= 1'b1;
    end else begin
      prev_start <= bus.startn;
      prev_stop  <= bus.stopn;
    end
  end

  contador_tempo #(
    .TICKS_POR_SEG (TICKS_POR_SEG),
    .T_W           (T_W)
  ) u_contador (
    .clk      (clk),
    .rst      (rst),
    .clr      (c_clr),
    .load     (c_load),
    .load_val (bus.tempo_in),
    .reinicia (c_reinicia),
    .conta    (c_conta),
    .decr     (c_decr),
    .tick     (tick),
    .zero     (zero),
    .tempo    (tempo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      estado <= OCIOSO;
    else
      estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    c_clr       = 1'b0;
    c_load      = 1'b0;
    c_reinicia  = 1'b0;
    c_conta     = 1'b0;
    c_decr      = 1'b0;
    beep_clr    = 1'b0;
    if (!bus.clrn) begin
      estado_prox = OCIOSO;
      c_clr       = 1'b1;
    end else begin
      case (estado)
        OCIOSO: begin
          // A button event, even an ineffective one, masks carregar this cycle.
          if (!ev_stop) begin
            if (ev_start) begin
              if (bus.porta_fechada && !zero) begin
                estado_prox = AQUECENDO;
                c_reinicia  = 1'b1;
              end
            end else if (bus.carregar) begin
              c_load = 1'b1;
            end
          end
        end
        AQUECENDO: begin
          // Leaving for PAUSADO freezes the phase, so the last tick cannot land.
          if (!bus.porta_fechada || ev_stop) begin
            estado_prox = PAUSADO;
          end else begin
            c_conta = 1'b1;
            c_decr  = 1'b1;
            if (tick && (tempo == T_W'(1))) begin
              estado_prox = CONCLUIDO;
              c_reinicia  = 1'b1;
              beep_clr    = 1'b1;
            end
          end
        end
        PAUSADO: begin
          if (ev_stop) begin
            estado_prox = OCIOSO;
            c_clr       = 1'b1;
          end else if (ev_start && bus.porta_fechada) begin
            estado_prox = AQUECENDO;
          end
        end
        CONCLUIDO: begin
          if (ev_stop) begin
            estado_prox = OCIOSO;
          end else begin
            c_conta = 1'b1;
            if (tick && (beep_cnt == BEEP_ULT))
              estado_prox = OCIOSO;
          end
        end
        default: estado_prox = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      beep_cnt <= '0;
    else if (beep_clr)
      beep_cnt <= '0;
    else if ((estado == CONCLUIDO) && tick)
      beep_cnt <= beep_cnt + 1'b1;
  end

`ifdef NIVEL_POTENCIA_EN
  logic [3:0] janela;
  logic       janela_clr;

  // Ten-second duty window: magnetron is on for the first nivel seconds of each.
  assign janela_clr = !bus.clrn || ((estado == OCIOSO) && (estado_prox == AQUECENDO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      janela <= '0;
    else if (janela_clr)
      janela <= '0;
    else if ((estado == AQUECENDO) && tick)
      janela <= (janela == 4'd9) ? 4'd0 : janela + 4'd1;
  end

  assign bus.ligar = (estado == AQUECENDO) && (janela < satura_nivel(bus.nivel));
`else
  assign bus.ligar = (estado == AQUECENDO);
`endif

  assign bus.alarme         = (estado == CONCLUIDO);
  assign bus.estado         = estado;
  assign bus.zero           = zero;
  assign bus.tempo_restante = tempo;

endmodule

// File: tb/tb_controlador_microondas.sv
// Bench for controlador_microondas: directed scenarios then random panel
// activity, all checked against a cycle-level behavioural model.
module tb_controlador_microondas;

  localparam int TPS  = 4;
  localparam int TW   = 12;
  localparam int BEEP = 3;

  localparam int M_IDLE  = 0;
  localparam int M_COOK  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  controlador_microondas_if #(.T_W(TW)) bus ();

  controlador_microondas #(
    .TICKS_POR_SEG (TPS),
    .T_W           (TW),
    .BEEP_SEG      (BEEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode, whole seconds left, cycles into the current second.
  int m_mode, m_time, m_phase, m_beep_left, m_win;
  int m_prev_start, m_prev_stop;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_time = 0; m_phase = 0; m_beep_left = 0; m_win = 0;
    m_prev_start = 1; m_prev_stop = 1;
  endtask

  task automatic model_step();
    bit sev, pev;
    sev = (bus.startn == 1'b0) && (m_prev_start == 1);
    pev = (bus.stopn == 1'b0) && (m_prev_stop == 1);
    m_prev_start = int'(bus.startn);
    m_prev_stop  = int'(bus.stopn);
    if (!bus.clrn) begin
      m_mode = M_IDLE; m_time = 0; m_phase = 0; m_win = 0;
    end else if (m_mode == M_IDLE) begin
      if (!pev && sev) begin
        if (bus.porta_fechada && m_time != 0) begin
          m_mode = M_COOK; m_phase = 0; m_win = 0;
        end
      end else if (!pev && bus.carregar) begin
        m_time = int'(bus.tempo_in);
      end
    end else if (m_mode == M_COOK) begin
      if (!bus.porta_fechada || pev) begin
        m_mode = M_PAUSE;
      end else begin
        m_phase++;
        if (m_phase == TPS) begin
          m_phase = 0;
          m_time--;
          m_win = (m_win + 1) % 10;
          if (m_time == 0) begin
            m_mode = M_DONE;
            m_beep_left = BEEP * TPS;
          end
        end
      end
    end else if (m_mode == M_PAUSE) begin
      if (pev) begin
        m_mode = M_IDLE; m_time = 0; m_phase = 0;
      end else if (sev && bus.porta_fechada) begin
        m_mode = M_COOK;
      end
    end else begin
      if (pev) begin
        m_mode = M_IDLE;
      end else begin
        m_beep_left--;
        if (m_beep_left == 0) m_mode = M_IDLE;
      end
    end
  endtask

  task automatic check_all(string tag);
    int exp_ligar;
    exp_ligar = (m_mode == M_COOK) ? 1 : 0;
`ifdef NIVEL_POTENCIA_EN
    begin
      int sat;
      sat = (int'(bus.nivel) > 10) ? 10 : int'(bus.nivel);
      if (m_win >= sat) exp_ligar = 0;
    end
`endif
    check({tag, ".ligar"},  32'(bus.ligar),          exp_ligar);
    check({tag, ".alarme"}, 32'(bus.alarme),         (m_mode == M_DONE) ? 1 : 0);
    check({tag, ".zero"},   32'(bus.zero),           (m_time == 0) ? 1 : 0);
    check({tag, ".tempo"},  32'(bus.tempo_restante), m_time);
    check({tag, ".estado"}, 32'(bus.estado),         m_mode);
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic run(int n, string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic load(int v, string tag);
    bus.carregar = 1'b1;
    bus.tempo_in = TW'(v);
    cycle(tag);
    bus.carregar = 1'b0;
  endtask

  task automatic press_start(string tag);
    bus.startn = 1'b0;
    cycle(tag);
    bus.startn = 1'b1;
  endtask

  task automatic press_stop(string tag);
    bus.stopn = 1'b0;
    cycle(tag);
    bus.stopn = 1'b1;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, ".ligar"},  32'(bus.ligar),          0);
    check({tag, ".alarme"}, 32'(bus.alarme),         0);
    check({tag, ".zero"},   32'(bus.zero),           1);
    check({tag, ".tempo"},  32'(bus.tempo_restante), 0);
    check({tag, ".estado"}, 32'(bus.estado),         0);
  endtask

  initial begin
    rst = 1'b1;
    bus.startn = 1'b1; bus.stopn = 1'b1; bus.clrn = 1'b1;
    bus.porta_fechada = 1'b1; bus.carregar = 1'b0; bus.tempo_in = '0;
`ifdef NIVEL_POTENCIA_EN
    bus.nivel = 4'd10;
`endif
    model_reset();
    #12;
    check_reset_values("reset");
    rst = 1'b0;

    // Full cook of 3 s followed by the alarm.
    load(3, "s1_load");
    press_start("s1_start");
    check("s1_ligar_on", 32'(bus.ligar), 1);
    run(11, "s1_cook");
    check("s1_tempo_last", 32'(bus.tempo_restante), 1);
    run(1, "s1_end");
    check("s1_concluido", 32'(bus.estado), 3);
    check("s1_zero", 32'(bus.zero), 1);
    check("s1_alarme", 32'(bus.alarme), 1);
    run(11, "s1_beep");
    check("s1_alarme_hold", 32'(bus.alarme), 1);
    run(1, "s1_beep_end");
    check("s1_ocioso", 32'(bus.estado), 0);

    // Door opens mid-second at 2 s; resume keeps the second's phase.
    load(5, "s2_load");
    press_start("s2_start");
    run(14, "s2_cook");
    bus.porta_fechada = 1'b0;
    cycle("s2_door");
    check("s2_pausado", 32'(bus.estado), 2);
    check("s2_ligar_off", 32'(bus.ligar), 0);
    run(5, "s2_hold");
    check("s2_tempo_held", 32'(bus.tempo_restante), 2);
    bus.porta_fechada = 1'b1;
    press_start("s2_resume");
    run(2, "s2_phase");
    check("s2_tempo_phase", 32'(bus.tempo_restante), 1);
    run(4, "s2_tail");
    check("s2_concluido", 32'(bus.estado), 3);
    run(12, "s2_beep");

    // Stop pauses, held stop is a single event, second stop cancels.
    load(4, "s3_load");
    press_start("s3_start");
    run(3, "s3_cook");
    bus.stopn = 1'b0;
    cycle("s3_stop1");
    check("s3_pausado", 32'(bus.estado), 2);
    run(4, "s3_stop_held");
    check("s3_held_once", 32'(bus.estado), 2);
    bus.stopn = 1'b1;
    cycle("s3_release");
    press_stop("s3_stop2");
    check("s3_cancel_estado", 32'(bus.estado), 0);
    check("s3_cancel_tempo", 32'(bus.tempo_restante), 0);

    // Ignored starts, then a valid one; start+stop together.
    press_start("s4_start_zero");
    check("s4_zero_ignored", 32'(bus.estado), 0);
    load(2, "s4_load");
    bus.porta_fechada = 1'b0;
    press_start("s4_start_open");
    check("s4_open_ignored", 32'(bus.estado), 0);
    bus.porta_fechada = 1'b1;
    cycle("s4_close");
    press_start("s4_start_ok");
    check("s4_aquecendo", 32'(bus.estado), 1);
    run(8, "s4_cook");
    check("s4_concluido", 32'(bus.estado), 3);
    run(12, "s4_beep");
    load(2, "s4_load2");
    bus.startn = 1'b0; bus.stopn = 1'b0;
    cycle("s4_both");
    check("s4_stop_wins", 32'(bus.estado), 0);
    bus.startn = 1'b1; bus.stopn = 1'b1;
    cycle("s4_idle");

    // clrn overrides carregar; asynchronous reset mid-cook.
    load(6, "s5_load");
    press_start("s5_start");
    run(3, "s5_cook");
    bus.clrn = 1'b0; bus.carregar = 1'b1; bus.tempo_in = TW'(9);
    cycle("s5_clr");
    check("s5_clr_tempo", 32'(bus.tempo_restante), 0);
    run(2, "s5_clr_hold");
    bus.clrn = 1'b1; bus.carregar = 1'b0;
    cycle("s5_unclr");
    load(7, "s5_load2");
    press_start("s5_start2");
    run(5, "s5_cook2");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_values("s5_rst");
    #1;
    rst = 1'b0;
    cycle("s5_after_rst");

    // Door opens on the final-tick cycle.
    load(1, "s6_load");
    press_start("s6_start");
    run(3, "s6_cook");
    bus.porta_fechada = 1'b0;
    cycle("s6_door");
    check("s6_pausado", 32'(bus.estado), 2);
    check("s6_tempo_one", 32'(bus.tempo_restante), 1);
    check("s6_no_alarme", 32'(bus.alarme), 0);
    bus.porta_fechada = 1'b1;
    press_stop("s6_cancel");

`ifdef NIVEL_POTENCIA_EN
    begin
      int ones;
      bus.nivel = 4'd3;
      load(10, "p_load");
      press_start("p_start");
      ones = int'(bus.ligar);
      for (int i = 0; i < 39; i++) begin
        cycle("p_cook");
        ones += int'(bus.ligar);
      end
      check("p_ligar_ones", ones, 12);
      run(13, "p_end");
      bus.nivel = 4'd10;
    end
`endif

    // Random panel activity, alternating busy and quiet stretches.
    for (int i = 0; i < 2000; i++) begin
      bit quiet;
      quiet = ((i / 100) % 2) == 1;
      bus.startn = ($urandom_range(0, quiet ? 29 : 5) == 0) ? 1'b0 : 1'b1;
      bus.stopn  = ($urandom_range(0, quiet ? 79 : 12) == 0) ? 1'b0 : 1'b1;
      bus.porta_fechada = ($urandom_range(0, quiet ? 99 : 15) == 0) ? 1'b0 : 1'b1;
      bus.clrn = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      bus.carregar = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      bus.tempo_in = TW'($urandom_range(0, 5));
`ifdef NIVEL_POTENCIA_EN
      bus.nivel = 4'($urandom_range(0, 15));
`endif
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
